// File: rtl/path_delay_scheduler_if.sv
// Handshake and path-control bundle between the delay scheduler and its environment
// (launch driver, result mux, capture register, readout).
interface path_delay_scheduler_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic             path_result;
  logic             res_ready;
  logic [SEL_W-1:0] path_sel;
  logic             path_input;
  logic             ld_reg;
  logic             res_valid;
  logic [SEL_W-1:0] meas_path;
  logic             meas_edge;
  logic [CNT_W-1:0] meas_count;
  logic             meas_timeout;
  logic             busy;
  logic             done;

  modport master (
    output start, path_result, res_ready,
    input  path_sel, path_input, ld_reg, res_valid, meas_path, meas_edge,
           meas_count, meas_timeout, busy, done
  );

  modport slave (
    input  start, path_result, res_ready,
    output path_sel, path_input, ld_reg, res_valid, meas_path, meas_edge,
           meas_count, meas_timeout, busy, done
  );
endinterface

// File: rtl/path_delay_scheduler.sv
// Sweeps rise/fall delay measurements over NUM_PATHS paths sharing one launch driver,
// counting cycles until the selected path follows and streaming results over valid/ready.
module path_delay_scheduler #(
  parameter int NUM_PATHS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 200,
  parameter int SETTLE    = 4
) (
  input logic clk,
  input logic rst,
  path_delay_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRESET, LAUNCH, WAIT, LOAD, HOLD, NEXT} state_t;

  localparam logic [CNT_W-1:0] TO_C      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_P    = SEL_W'(NUM_PATHS - 1);

  state_t           state, stateN;
  logic [CNT_W-1:0] cnt, cntN;
  logic [SEL_W-1:0] path, pathN;
  logic             edgeSel, edgeN;
  logic             pathInput, pathInputN;
  logic             ldReg, ldRegN;
  logic             resValid, resValidN;
  logic [SEL_W-1:0] measPath, measPathN;
  logic             measEdge, measEdgeN;
  logic [CNT_W-1:0] measCount, measCountN;
  logic             measTimeout, measTimeoutN;
  logic             busyR, busyN;
  logic             doneR, doneN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      path        <= '0;
      edgeSel     <= 1'b0;
      pathInput   <= 1'b0;
      ldReg       <= 1'b0;
      resValid    <= 1'b0;
      measPath    <= '0;
      measEdge    <= 1'b0;
      measCount   <= '0;
      measTimeout <= 1'b0;
      busyR       <= 1'b0;
      doneR       <= 1'b0;
    end else begin
      state       <= stateN;
      cnt         <= cntN;
      path        <= pathN;
      edgeSel     <= edgeN;
      pathInput   <= pathInputN;
      ldReg       <= ldRegN;
      resValid    <= resValidN;
      measPath    <= measPathN;
      measEdge    <= measEdgeN;
      measCount   <= measCountN;
      measTimeout <= measTimeoutN;
      busyR       <= busyN;
      doneR       <= doneN;
    end
  end

  // Target level is ~edgeSel, so the preset level equals edgeSel.
  always_comb begin
    stateN       = state;
    cntN         = cnt;
    pathN        = path;
    edgeN        = edgeSel;
    pathInputN   = pathInput;
    ldRegN       = 1'b0;
    resValidN    = resValid;
    measPathN    = measPath;
    measEdgeN    = measEdge;
    measCountN   = measCount;
    measTimeoutN = measTimeout;
    busyN        = busyR;
    doneN        = 1'b0;
    case (state)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (bus.start && !doneR) begin
          stateN     = PRESET;
          busyN      = 1'b1;
          pathN      = '0;
          edgeN      = 1'b0;
          cntN       = '0;
          pathInputN = 1'b0;
        end
      end
      PRESET: begin
        if (cnt >= SETTLE_M1 && bus.path_result == edgeSel) begin
          stateN     = LAUNCH;
          pathInputN = ~edgeSel;
        end else if (cnt == TO_C) begin
          stateN       = LOAD;
          ldRegN       = 1'b1;
          measPathN    = path;
          measEdgeN    = edgeSel;
          measCountN   = '0;
          measTimeoutN = 1'b1;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      LAUNCH: begin
        cntN   = '0;
        stateN = WAIT;
      end
      WAIT: begin
        if (bus.path_result == ~edgeSel) begin
          stateN       = LOAD;
          ldRegN       = 1'b1;
          measPathN    = path;
          measEdgeN    = edgeSel;
          measCountN   = cnt;
          measTimeoutN = 1'b0;
        end else if (cnt == TO_C) begin
          stateN       = LOAD;
          ldRegN       = 1'b1;
          measPathN    = path;
          measEdgeN    = edgeSel;
          measCountN   = TO_C;
          measTimeoutN = 1'b1;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      LOAD: begin
        stateN    = HOLD;
        resValidN = 1'b1;
      end
      HOLD: begin
        if (bus.res_ready) begin
          resValidN = 1'b0;
          stateN    = NEXT;
        end
      end
      NEXT: begin
        if (!edgeSel) begin
          edgeN      = 1'b1;
          pathInputN = 1'b1;
          cntN       = '0;
          stateN     = PRESET;
        end else if (path != LAST_P) begin
          pathN      = path + 1'b1;
          edgeN      = 1'b0;
          pathInputN = 1'b0;
          cntN       = '0;
          stateN     = PRESET;
        end else begin
          stateN     = IDLE;
          doneN      = 1'b1;
          busyN      = 1'b0;
          pathInputN = 1'b0;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  assign bus.path_sel     = path;
  assign bus.path_input   = pathInput;
  assign bus.ld_reg       = ldReg;
  assign bus.res_valid    = resValid;
  assign bus.meas_path    = measPath;
  assign bus.meas_edge    = measEdge;
  assign bus.meas_count   = measCount;
  assign bus.meas_timeout = measTimeout;
  assign bus.busy         = busyR;
  assign bus.done         = doneR;
endmodule

// File: tb/tb_path_delay_scheduler.sv
// Randomized scoreboard bench: each sweep's expected results are derived from per-path
// loopback delays / stuck paths and compared at every valid&ready transfer.
module tb_path_delay_scheduler;
  localparam int NP = 4, SW = 2, CW = 8, TO = 30, ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  path_delay_scheduler_if #(.SEL_W(SW), .CNT_W(CW)) bus ();

  path_delay_scheduler #(
    .NUM_PATHS(NP), .SEL_W(SW), .CNT_W(CW), .TIMEOUT(TO), .SETTLE(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int p;
    int e;
    int cnt;
    int to;
    int pin;
  } res_t;

  res_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   delay[NP];
  bit   tied[NP];
  bit   holdReady = 1'b0;
  int   doneCount = 0;
  int   expDone = 0;
  int   ldPending = 0;

  // Environment: D-stage registered loopback per path, or a path stuck at 0.
  logic [7:0] hist;
  always @(posedge clk or posedge rst)
    if (rst) hist <= '0;
    else     hist <= {hist[6:0], bus.path_input};
  always_comb bus.path_result = tied[bus.path_sel] ? 1'b0 : hist[delay[bus.path_sel]-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each transfer and watches HOLD stability.
  initial begin
    bit prevHeld = 1'b0;
    logic [SW+CW+2:0] snap = '0;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ldPending = 0;
        prevHeld  = 1'b0;
        continue;
      end
      if (bus.ld_reg) ldPending++;
      if (bus.res_valid && prevHeld)
        check("hold_stable",
              {bus.meas_path, bus.meas_edge, bus.meas_count, bus.meas_timeout, bus.path_input}, snap);
      prevHeld = bus.res_valid && !bus.res_ready;
      snap = {bus.meas_path, bus.meas_edge, bus.meas_count, bus.meas_timeout, bus.path_input};
      if (bus.res_valid && bus.res_ready) begin
        if (expQ.size() == 0) check("unexpected_result", 1, 0);
        else begin
          e = expQ.pop_front();
          check("result_path", bus.meas_path, e.p);
          check("result_edge", bus.meas_edge, e.e);
          check("result_count", bus.meas_count, e.cnt);
          check("result_timeout", bus.meas_timeout, e.to);
          check("result_path_input", bus.path_input, e.pin);
          check("path_sel_match", bus.path_sel, bus.meas_path);
          check("ld_pulses", ldPending, 1);
        end
        ldPending = 0;
      end
      if (bus.done) begin
        doneCount++;
        check("done_after_last", expQ.size(), 0);
      end
    end
  end

  // Expected sweep from path properties alone.
  task automatic push_expected();
    res_t r;
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < 2; e++) begin
        r.p = p;
        r.e = e;
        if (tied[p]) begin
          r.cnt = (e == 0) ? TO : 0;
          r.to  = 1;
          r.pin = 1;
        end else begin
          r.cnt = delay[p] - 1;
          r.to  = 0;
          r.pin = (e == 0) ? 1 : 0;
        end
        expQ.push_back(r);
      end
  endtask

  task automatic run_sweep(input bit midStarts, input bit startOnDone, input bit holdFirst);
    bit got = 1'b0;
    holdReady = holdFirst;
    push_expected();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (holdFirst) begin
      for (int c = 0; c < 200 && !bus.res_valid; c++) begin
        @(posedge clk); #1;
      end
      check("hold_reached_valid", bus.res_valid, 1);
      repeat (10) @(posedge clk);
      #1;
      check("hold_still_valid", bus.res_valid, 1);
      check("hold_first_result", {bus.meas_path, bus.meas_edge}, 0);
      holdReady = 1'b0;
    end
    for (int c = 0; c < 3000 && !got; c++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (midStarts && $urandom_range(0, 15) == 0) bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
      end
    end
    if (!got) check("sweep_done_timeout", 0, 1);
    else begin
      expDone++;
      if (startOnDone) begin
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check("start_on_done_ignored", bus.busy, 0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    for (int p = 0; p < NP; p++) begin
      delay[p] = p + 1;
      tied[p]  = 1'b0;
    end
    #1;
    check("reset_outputs",
          {bus.path_sel, bus.path_input, bus.ld_reg, bus.res_valid, bus.meas_path,
           bus.meas_edge, bus.meas_count, bus.meas_timeout, bus.busy, bus.done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", bus.busy, 0);

    // Delays 1..4: counts 0,0,1,1,2,2,3,3.
    run_sweep(1'b0, 1'b0, 1'b0);
    // Readout stalls on the first result.
    for (int p = 0; p < NP; p++) delay[p] = $urandom_range(1, 7);
    run_sweep(1'b0, 1'b0, 1'b1);
    // All paths stuck at 0, with start pulses during the sweep and on done.
    for (int p = 0; p < NP; p++) tied[p] = 1'b1;
    run_sweep(1'b1, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < NP; p++) begin
        delay[p] = $urandom_range(1, 7);
        tied[p]  = ($urandom_range(0, 3) == 0);
      end
      run_sweep(1'(s % 2), 1'b1, 1'b0);
    end

    // Reset while waiting on a stuck path with the readout stalled.
    for (int p = 0; p < NP; p++) tied[p] = 1'b0;
    tied[0] = 1'b1;
    holdReady = 1'b1;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 0; c < 100 && !bus.path_input; c++) begin
      @(posedge clk); #1;
    end
    check("launched_before_rst", bus.path_input, 1);
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_path_input", bus.path_input, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tied[0] = 1'b0;
    holdReady = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_mid_rst", {bus.busy, bus.res_valid, bus.ld_reg, bus.path_input}, 0);

    // Fresh sweep after the abort starts again at path 0.
    run_sweep(1'b0, 1'b0, 1'b0);
    check("done_count", doneCount, expDone);
    check("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
